// File: rtl/grf.sv
// General register file: 32 x 32-bit registers, two combinational read
// ports with same-cycle write bypass, one synchronous write port, and
// an asynchronous active-low clear. $0 is hard-wired to zero.
// Committed writes emit a simulation log line tagged with the writer's PC.
module grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        regwrite,
  input  logic [31:0] pc_new,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  // Entry 0 exists only so every 5-bit index is in range. It is cleared
  // by reset, never written, and masked on the read side as well.
  logic [31:0] regs [0:31];

  // A write commits only outside reset and never to $0.
  logic write_en;

  // Qualify the write; the same term drives storage, bypass and the log.
  always_comb begin
    write_en = reset && regwrite && (write_reg != 5'd0);
  end

  // Storage: asynchronous clear, otherwise one write per rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

`ifndef SYNTHESIS
  // Write log for simulation only; it does not touch any design state.
  always_ff @(posedge clk) begin
    if (write_en) begin
      $display("@%h: $%2d <= %h", pc_new, write_reg, write_data);
    end
  end
`else
  logic unused_pc;
  always_comb begin
    unused_pc = ^pc_new;
  end
`endif

  // Read port 1: zero in reset or for $0, bypass the in-flight write,
  // otherwise the stored value.
  always_comb begin
    read_data1 = 32'd0;
    if (reset && (read_reg1 != 5'd0)) begin
      if (write_en && (write_reg == read_reg1)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs[read_reg1];
      end
    end
  end

  // Read port 2: identical selection logic, independent index.
  always_comb begin
    read_data2 = 32'd0;
    if (reset && (read_reg2 != 5'd0)) begin
      if (write_en && (write_reg == read_reg2)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs[read_reg2];
      end
    end
  end

endmodule

// File: tb/tb_grf.sv
// Bench for grf: reset sweep, a table of directed vectors, hand-written
// async-reset sequences, then random traffic against a register model.
module tb_grf;

  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regwrite;
  logic [31:0] pc_new;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mdl [0:31];

  grf dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regwrite   (regwrite),
    .pc_new     (pc_new),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sync;   // wait for the next falling edge before applying
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] pc;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;     // expected before the next rising edge
    logic [31:0] e2;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic compare(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, queue the expected port values, and compare 1 ns later.
  task automatic drive(input logic [4:0] wr, input logic [31:0] wd,
                       input logic we, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input string name);
    logic [31:0] x;
    write_reg  = wr;
    write_data = wd;
    regwrite   = we;
    pc_new     = pc;
    read_reg1  = r1;
    read_reg2  = r2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    #1;
    x = exp_q.pop_front();
    compare({name, ".rd1"}, read_data1, x);
    x = exp_q.pop_front();
    compare({name, ".rd2"}, read_data2, x);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx,
                                             input logic [4:0] wr,
                                             input logic [31:0] wd,
                                             input logic we);
    if (idx == 5'd0) return 32'd0;
    if (we && (wr == idx)) return wd;
    return mdl[idx];
  endfunction

  initial begin
    reset = 1'b0;
    write_reg = '0; write_data = '0; regwrite = 1'b0; pc_new = '0;
    read_reg1 = '0; read_reg2 = '0;

    // Directed table: each row's expected values hold before its edge.
    vecs.push_back('{1, 5'd5,  32'h12345678, 1, 32'h3000, 5'd5,  5'd0,  32'h12345678, 32'h0,        "basic_bypass"});
    vecs.push_back('{1, 5'd0,  32'h0,        0, 32'h3004, 5'd5,  5'd5,  32'h12345678, 32'h12345678, "basic_read"});
    vecs.push_back('{1, 5'd0,  32'hFFFFFFFF, 1, 32'h3008, 5'd0,  5'd0,  32'h0,        32'h0,        "zero_write"});
    vecs.push_back('{1, 5'd0,  32'h0,        0, 32'h300C, 5'd0,  5'd5,  32'h0,        32'h12345678, "zero_after"});
    vecs.push_back('{1, 5'd8,  32'h1,        1, 32'h3010, 5'd8,  5'd1,  32'h1,        32'h0,        "set8"});
    vecs.push_back('{1, 5'd8,  32'hABCD0000, 1, 32'h3014, 5'd5,  5'd8,  32'h12345678, 32'hABCD0000, "bypass8"});
    vecs.push_back('{0, 5'd8,  32'hABCD0000, 0, 32'h3014, 5'd5,  5'd8,  32'h12345678, 32'h1,        "bypass8_off"});
    vecs.push_back('{1, 5'd0,  32'h0,        0, 32'h3018, 5'd8,  5'd8,  32'h1,        32'h1,        "hold8"});
    vecs.push_back('{1, 5'd9,  32'h55,       0, 32'h301C, 5'd9,  5'd9,  32'h0,        32'h0,        "we_off"});
    vecs.push_back('{1, 5'd0,  32'h0,        0, 32'h3020, 5'd9,  5'd8,  32'h0,        32'h1,        "we_off_after"});
    vecs.push_back('{1, 5'd31, 32'hDEADBEEF, 1, 32'h3024, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, "same_idx_bypass"});
    vecs.push_back('{1, 5'd5,  32'h12345678, 1, 32'h3028, 5'd31, 5'd5,  32'hDEADBEEF, 32'h12345678, "rewrite_same"});
    vecs.push_back('{1, 5'd0,  32'h0,        0, 32'h302C, 5'd31, 5'd3,  32'hDEADBEEF, 32'h0,        "read31"});

    // Reset held for 20 ns, released at a falling edge.
    #20;
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(5'd0, 32'h0, 1'b0, 32'h0, i[4:0], i[4:0], 32'h0, 32'h0, "reset_clear");
    end

    foreach (vecs[k]) begin
      if (vecs[k].sync) @(negedge clk);
      drive(vecs[k].wr, vecs[k].wd, vecs[k].we, vecs[k].pc,
            vecs[k].r1, vecs[k].r2, vecs[k].e1, vecs[k].e2, vecs[k].name);
    end

    // Async reset between edges with a write pending on $31.
    @(negedge clk);
    drive(5'd31, 32'h00000777, 1'b1, 32'h4000, 5'd31, 5'd5,
          32'h00000777, 32'h12345678, "pending_bypass");
    reset = 1'b0;
    drive(5'd31, 32'h00000777, 1'b1, 32'h4000, 5'd31, 5'd31,
          32'h0, 32'h0, "async_clear");
    @(posedge clk);
    #1;
    drive(5'd31, 32'h00000777, 1'b1, 32'h4000, 5'd31, 5'd8,
          32'h0, 32'h0, "edge_in_reset");
    @(negedge clk);
    reset = 1'b1;
    drive(5'd7, 32'hCAFEF00D, 1'b0, 32'h4004, 5'd31, 5'd5,
          32'h0, 32'h0, "write_lost");
    drive(5'd7, 32'hCAFEF00D, 1'b1, 32'h4004, 5'd7, 5'd31,
          32'hCAFEF00D, 32'h0, "first_write_bypass");
    @(negedge clk);
    drive(5'd0, 32'h0, 1'b0, 32'h4008, 5'd7, 5'd7,
          32'hCAFEF00D, 32'hCAFEF00D, "first_write");

    // Short reset pulse between edges, then random traffic vs the model.
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    drive(5'd0, 32'h0, 1'b0, 32'h0, 5'd7, 5'd31, 32'h0, 32'h0, "pulse_clear");
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

    for (int n = 0; n < 200; n++) begin
      logic [4:0]  wr, r1, r2;
      logic [31:0] wd;
      logic        we;
      @(negedge clk);
      wr = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      drive(wr, wd, we, 32'h5000 + 32'(n * 4), r1, r2,
            model_read(r1, wr, wd, we), model_read(r2, wr, wd, we), "random");
      if (we && (wr != 5'd0)) mdl[wr] = wd;
    end

    @(negedge clk);
    regwrite = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
